// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite types: transfer/size encodings, response codes and the SRAM slave FSM states.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } ahb_slv_state_e;

    // Mask of the address bits that must be zero for a naturally aligned transfer of this size.
    function automatic logic [7:0] size_mask(input logic [2:0] hsize);
        return 8'((16'd1 << hsize) - 16'd1);
    endfunction

endpackage

// File: rtl/ahb_if.sv
// AHB-Lite bus bundle between a master/decoder and one slave.
interface ahb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic [DATA_W-1:0] hwdata;
    logic              hreadyin;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic              hresp;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hreadyin,
        output hrdata, hready, hresp
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hreadyin,
        input  hrdata, hready, hresp
    );
endinterface

// File: rtl/ahb_byte_lane_decoder.sv
// Converts transfer size and low address bits into a little-endian byte-lane write strobe.
module ahb_byte_lane_decoder #(
    parameter int DATA_W = 32
) (
    input  logic [2:0]                 hsize,
    input  logic [$clog2(DATA_W/8)-1:0] addr_lo,
    output logic [DATA_W/8-1:0]        strb
);
    localparam int NB = DATA_W / 8;
    localparam int LW = $clog2(NB);
    localparam int SW = LW + 1;

    logic [SW-1:0] nbytes;
    logic [SW-1:0] lane_lo;
    logic [SW-1:0] lane_hi;

    // Low address bits inside the transfer size are masked off, so the strobe is always aligned.
    always_comb begin
        nbytes  = (hsize > 3'(LW)) ? SW'(NB) : (SW'(1) << hsize);
        lane_lo = {1'b0, addr_lo} & ~(nbytes - SW'(1));
        lane_hi = lane_lo + nbytes;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign strb[gi] = (SW'(gi) >= lane_lo) && (SW'(gi) < lane_hi);
        end
    endgenerate

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// Parametrised AHB-Lite SRAM slave with per-beat wait states, two-cycle ERROR and byte-lane writes.
// Define AHB_SLV_ALIGN_CHECK_EN to answer misaligned transfers with ERROR instead of force-aligning them.
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0
) (
    input logic  hclk,
    input logic  hresetn,
    ahb_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int LW    = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ahb_slv_state_e   state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LW-1:0]    lo_q, lo_d;
    logic [2:0]       size_q, size_d;
    logic             write_q, write_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [NB-1:0]     strb;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] word_idx;
    logic              accept;
    logic              misaligned;
    logic              addr_err;
    logic              complete;
    logic              load;
    logic              hready_o;
    logic              hresp_o;
    logic              unused_ok;

    assign unused_ok = ^{bus.hburst, bus.hprot};

    assign accept   = bus.hsel && bus.hreadyin &&
                      (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ);
    assign offset   = bus.haddr - BASE_ADDR;
    assign word_idx = offset >> LW;

`ifdef AHB_SLV_ALIGN_CHECK_EN
    assign misaligned = (8'(bus.haddr[LW-1:0]) & size_mask(bus.hsize)) != 8'd0;
`else
    assign misaligned = 1'b0;
`endif

    assign addr_err = (bus.haddr < BASE_ADDR) || (word_idx >= ADDR_W'(DEPTH)) ||
                      (bus.hsize > 3'(LW)) || misaligned;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        lo_d     = lo_q;
        size_d   = size_q;
        write_d  = write_q;
        hready_o = 1'b1;
        hresp_o  = HRESP_OKAY;
        complete = 1'b0;
        load     = 1'b0;

        case (state_q)
            ST_IDLE: load = 1'b1;
            ST_DATA: begin
                if (cnt_q != 4'd0) begin
                    hready_o = 1'b0;
                    cnt_d    = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    load     = 1'b1;
                end
            end
            ST_ERR1: begin
                hready_o = 1'b0;
                hresp_o  = HRESP_ERROR;
                state_d  = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_o = HRESP_ERROR;
                load    = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Any cycle that ends with hready high can take the next pipelined address.
        if (load) begin
            if (accept) begin
                idx_d   = word_idx[IDX_W-1:0];
                lo_d    = bus.haddr[LW-1:0];
                size_d  = bus.hsize;
                write_d = bus.hwrite;
                state_d = addr_err ? ST_ERR1 : ST_DATA;
                cnt_d   = addr_err ? 4'd0 : 4'(WAIT_STATES);
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            lo_q    <= '0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    ahb_byte_lane_decoder #(
        .DATA_W (DATA_W)
    ) u_lanes (
        .hsize   (size_q),
        .addr_lo (lo_q),
        .strb    (strb)
    );

    // Memory contents survive reset, so the array has no reset branch.
    always_ff @(posedge hclk) begin
        if (complete && write_q) begin
            for (int i = 0; i < NB; i++) begin
                if (strb[i]) begin
                    mem[idx_q][i*8 +: 8] <= bus.hwdata[i*8 +: 8];
                end
            end
        end
    end

    assign bus.hrdata = (complete && !write_q) ? mem[idx_q] : '0;
    assign bus.hready = hready_o;
    assign bus.hresp  = hresp_o;

endmodule

// File: doc/ahb_lite_sram_slave.md
# ahb_lite_sram_slave

Parametrised AHB-Lite memory slave. Successor to the fixed-size AHB slave behind the bus interface, with configurable address/data width, depth, base address and per-beat wait states. Adds two-cycle ERROR responses for out-of-range and oversize transfers, and byte-lane writes. Sits on the AHB-Lite bus as a single selectable slave and is driven by the existing class-based bench through the `ahb_if` interface.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; only 32 or 64 are legal.
- `DEPTH`, 256, memory depth in `DATA_W`-bit words.
- `BASE_ADDR`, 0, byte address of word 0.
- `WAIT_STATES`, 0, wait cycles inserted per OKAY data phase; legal range 0..15.
- `hclk  in  1  bus clock`; all logic is on the rising edge.
- `hresetn  in  1  reset`: asynchronous, active-low.
- `hsel  in  1  slave select`.
- `haddr  in  ADDR_W  byte address`.
- `htrans  in  2`: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hwrite  in  1`: 1 = write.
- `hsize  in  3`: transfer size, log2 bytes.
- `hburst  in  3`: burst type; accepted and ignored.
- `hprot  in  4`: protection; accepted and ignored.
- `hwdata  in  DATA_W`: write data, valid in the data phase.
- `hreadyin  in  1`: bus HREADY; previous transfer complete.
- `hrdata  out  DATA_W`: read data.
- `hready  out  1`: slave HREADYOUT.
- `hresp  out  1`: 0 = OKAY, 1 = ERROR.

## Operation
- **Address phase accepted** when `hsel && hreadyin && htrans[1]`. On acceptance, latch `haddr`, `hwrite` and `hsize`, and compute the error flag.
- **IDLE/BUSY, or `hsel`=0:** no data phase; OKAY with zero wait.
- **Error flag** is set when either holds:
  - word index `(haddr-BASE_ADDR)>>log2(DATA_W/8)` ≥ `DEPTH`, or `haddr` < `BASE_ADDR`;
  - `hsize` > log2(`DATA_W/8`).
- **FSM states:** `ST_IDLE`, `ST_DATA`, `ST_ERR1`, `ST_ERR2`.
  - `ST_IDLE` → `ST_DATA` on an accepted good transfer; load the wait counter with `WAIT_STATES`.
  - `ST_IDLE` → `ST_ERR1` on an accepted bad transfer. No wait states are applied.
  - `ST_DATA`: `hready` = (counter==0). The counter decrements while nonzero.
  - At counter==0 the beat completes:
    - a write updates only the byte lanes selected by the registered `hsize` and low address bits (little-endian);
    - a read drives the word at the registered index onto `hrdata`.
    - In the same cycle, a new accepted address moves to `ST_DATA` or `ST_ERR1`; otherwise the FSM goes to `ST_IDLE`.
  - `ST_ERR1`: `hready`=0, `hresp`=1 → `ST_ERR2`.
  - `ST_ERR2`: `hready`=1, `hresp`=1. An address accepted this cycle is handled normally; otherwise → `ST_IDLE`.
  - The memory is never written for an errored transfer.
- **`hrdata`** is 0 except in the completing cycle of a good read.
- **Back-to-back write then read to the same word:** the read returns the newly written data. The write commits at the end of its data phase, before the read's data phase.
- **Bursts:** each beat carries its own `haddr`; there is no internal address increment. BUSY inside a burst returns OKAY with zero wait.
- **Reset:** in any state, reset forces `ST_IDLE`, counter=0, `hready`=1, `hresp`=0, `hrdata`=0.
  - An in-flight transfer is dropped.
  - Memory contents are not reset.

## Timing
- Zero-wait read: address in cycle N; `hrdata` valid and `hready`=1 in cycle N+1.
- Latency of a good beat: `WAIT_STATES`+1 cycles after address acceptance.
- ERROR: exactly 2 cycles (`hready` 0 then 1, `hresp` high in both).
- Addresses are pipelined: a new address phase overlaps the completing data-phase cycle.
- All outputs are registered or derived from registered state.
  - `hrdata` is a combinational read of the array at the registered index, gated by completion.

## Configuration
- `AHB_SLV_ALIGN_CHECK_EN`:
  - Defined: an address not aligned to `hsize` (e.g. word access at `haddr[1:0]`≠0) sets the error flag and produces a two-cycle ERROR.
  - Undefined: the low `hsize` address bits are forced to zero and the transfer proceeds as OKAY.

## Structure
- Package `ahb_lite_pkg` holds:
  - `htrans_e` (IDLE/BUSY/NONSEQ/SEQ);
  - `hsize_e` (BYTE/HALF/WORD/DWORD);
  - `HRESP_OKAY`/`HRESP_ERROR`;
  - the slave FSM state typedef `ahb_slv_state_e`.
- Sub-module `ahb_byte_lane_decoder` turns `hsize`, the low address bits and `DATA_W` into a `DATA_W/8` byte strobe.

## Test plan
- **Reset:** hold `hresetn`=0 for 1 cycle, then release → `hready`=1, `hresp`=0, `hrdata`=0.
- **Word round trip (`WAIT_STATES`=0):** write 0xDEADBEEF to 0x10, then read 0x10 → `hrdata`=0xDEADBEEF one cycle after the read address, zero waits.
- **Byte write:** byte write 0xAA to 0x13 over word 0x11223344 → read 0x10 returns 0xAA223344.
- **Wait states (`WAIT_STATES`=3):** read → `hready` low for 3 cycles, then data with `hready`=1.
- **Out of range (`DEPTH`=256, `DATA_W`=32):** write to 0x400 → `hresp`=1 for 2 cycles, `hready` 0 then 1, memory unchanged.
- **Misaligned, macro on:** word read at 0x02 → ERROR. **Macro off:** same read → OKAY, returns the word at 0x00.
